piu_pchinfo_table: RTL and testbench
====================================

# piu_pchinfo_table

Parametrised, runtime-writable successor to the PIU static patch-info ROM. After reset, it builds the per-patch static info table (patch type, Z-boundary location, X-boundary location) with a sequential initialisation walk, one entry per cycle. Once built, it serves multiple registered read ports and accepts a write port for runtime patch re-typing, e.g. after merge/split reconfiguration. It sits inside the PIU, between the patch-index decoder and the patch-instruction/boundary logic.

## Interface
Parameters:
- NUM_PCHROW, 3: patch-grid rows.
- NUM_PCHCOL, 6: patch-grid columns. Must be at least 4; elaboration fails otherwise.
- NUM_RDPORT, 2: independent read ports.
- PCHTYPE_BW, `PCHTYPE_BW: patch-type field width.
- BDLOC_BW, `BDLOC_BW: boundary-location field width.
- Derived parameters:
  - NUM_PCH = NUM_PCHROW*NUM_PCHCOL
  - PCHADDR_BW = clog2(NUM_PCH)
  - PCHSTAT_BW = PCHTYPE_BW + 2*BDLOC_BW
  - Entry packing is {pchtype, z_bd, x_bd}, with pchtype in the MSBs.

Ports (clock and reset first):
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous and active-high.
- init_done, out, 1: table is built and the block is accepting traffic.
- reinit_req, in, 1: one-cycle pulse that rebuilds the default table without a reset.
- rd_en, in, NUM_RDPORT: per-port read request.
- rd_idx, in, NUM_RDPORT*PCHADDR_BW: packed read indices; port p uses slice p.
- rd_valid, out, NUM_RDPORT: per-port read response valid.
- rd_data, out, NUM_RDPORT*PCHSTAT_BW: packed read data.
- rd_err, out, NUM_RDPORT: per-port out-of-range index flag, qualified by rd_valid.
- wr_en, in, 1: write request.
- wr_idx, in, PCHADDR_BW: write index.
- wr_data, in, PCHSTAT_BW: write data.
- wr_err, out, 1: one-cycle pulse for a rejected write.

## Operation
- FSM states:
  - INIT: cnt walks 0..NUM_PCH-1 and writes one default entry per clock edge. When cnt==NUM_PCH-1, the FSM writes that entry, moves to READY and sets init_done<=1 on the same edge.
  - READY: reads and writes are served.
  - A reinit_req seen in READY moves the FSM to INIT with cnt<=0 and init_done<=0.
  - A reinit_req seen in INIT restarts the walk at cnt<=0.
- Default entry for index I, with row = I / NUM_PCHCOL and col = I % NUM_PCHCOL. Rules are evaluated first-match:
  - r0 c0: ZT {I,E}
  - r1 c0: ZB {E,I}
  - r0 c1: MT {W,I}
  - r1 c1: MB {WE,I}
  - r0, c != NUM_PCHCOL-1: M {S,I}
  - r2, c not in {0, 1, NUM_PCHCOL-1}: M {N,I}
  - r1 c==NUM_PCHCOL-1: X {W,I}
  - r1 c==2 and c==NUM_PCHCOL-2, i.e. NUM_PCHCOL==4: AWE {I,I}
  - r1 c==2: AW {I,I}
  - r1 c==NUM_PCHCOL-2: AE {I,I}
  - r1, any other column: AC {I,I}
  - Anything else, including every row >= 3: I {I,I}
- Reads: each port is independent. While init_done==0, rd_en is ignored; no rd_valid is produced and no data is returned.
  - idx >= NUM_PCH: rd_data=0, rd_err=1.
  - Multiple ports may read the same index in the same cycle.
- Writes are accepted only when init_done==1.
  - wr_idx >= NUM_PCH: no table update, wr_err pulse.
  - wr_en while init_done==0: dropped, wr_err pulse.
- Simultaneous events:
  - Read and write to the same index in the same cycle: the read returns the pre-write value; the new value is visible from the next cycle.
  - reinit_req together with wr_en: reinit wins, the write is dropped and wr_err pulses.
  - reinit_req together with rd_en in READY: the read is served normally (pre-reinit data).

## Timing
- Reset (asynchronous) sets:
  - FSM state INIT, cnt=0
  - init_done=0
  - rd_valid=0, rd_data=0, rd_err=0
  - wr_err=0
  - Table contents are undefined until rebuilt.
- The walk starts at the first clk edge after rst deasserts. init_done is high after edge NUM_PCH (edge 18 with the default parameters).
- Read latency is 1 cycle: a request sampled on edge k gives rd_valid/rd_data/rd_err registered on edge k and visible during cycle k+1. rd_valid is a single-cycle pulse per request.
- Write: sampled on edge k, visible to reads sampled at edge k+1. wr_err is registered on edge k.
- An asynchronous reset asserted mid-walk or mid-read clears all outputs immediately. The walk restarts from 0 after rst deasserts.

## Test plan
- Reset release with default parameters: count cycles → init_done rises after edge 18; rd_en held high during INIT produces no rd_valid.
- Read all 18 indices on port 0 → idx0 ZT{I,E}, 1 MT{W,I}, 2 M{S,I}, 5 I{I,I}, 6 ZB{E,I}, 7 MB{WE,I}, 8 AW, 9 AC, 10 AE, 11 X{W,I}, 12 I, 14 M{N,I}, 17 I.
- Re-elaborate with NUM_PCHCOL=4, NUM_PCHROW=4 → idx6 AWE{I,I}, idx7 X{W,I}, idx12..15 I.
- In the same cycle, port0 reads idx9, port1 reads idx20, and wr_en writes idx9={X,W,I} → port0 returns AC with rd_err=0, port1 returns 0 with rd_err=1; the next read of idx9 returns {X,W,I}.
- Write idx3, then pulse reinit_req together with wr_en on idx4 → wr_err pulses, init_done drops for 18 cycles, then idx3 reads M{S,I} and idx4 reads M{S,I}.
- Assert rst at cnt=7 during the walk → outputs clear at once; after release, init_done rises 18 edges later with a correct table.

Source files
------------

// File: rtl/piu_pchinfo_table.sv
// piu_pchinfo_table: runtime-writable per-patch static info table (type, Z/X boundary).
// The table is built by a walk after reset/reinit and then served through registered read ports.
`ifndef PCHTYPE_BW
`define PCHTYPE_BW 4
`endif
`ifndef BDLOC_BW
`define BDLOC_BW 3
`endif

module piu_pchinfo_table #(
    parameter int NUM_PCHROW = 3,
    parameter int NUM_PCHCOL = 6,
    parameter int NUM_RDPORT = 2,
    parameter int PCHTYPE_BW = `PCHTYPE_BW,
    parameter int BDLOC_BW   = `BDLOC_BW,
    localparam int NUM_PCH    = NUM_PCHROW * NUM_PCHCOL,
    localparam int PCHADDR_BW = $clog2(NUM_PCH),
    localparam int PCHSTAT_BW = PCHTYPE_BW + 2 * BDLOC_BW
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_done,
    input  logic                             reinit_req,
    input  logic [NUM_RDPORT-1:0]            rd_en,
    input  logic [NUM_RDPORT*PCHADDR_BW-1:0] rd_idx,
    output logic [NUM_RDPORT-1:0]            rd_valid,
    output logic [NUM_RDPORT*PCHSTAT_BW-1:0] rd_data,
    output logic [NUM_RDPORT-1:0]            rd_err,
    input  logic                             wr_en,
    input  logic [PCHADDR_BW-1:0]            wr_idx,
    input  logic [PCHSTAT_BW-1:0]            wr_data,
    output logic                             wr_err
);
    if (NUM_PCHCOL < 4) begin : g_chk
        $error("piu_pchinfo_table: NUM_PCHCOL must be at least 4");
    end

    // Patch-type codes: I=0 ZT=1 ZB=2 MT=3 MB=4 M=5 X=6 AW=7 AE=8 AC=9 AWE=10.
    localparam logic [PCHTYPE_BW-1:0] T_I   = PCHTYPE_BW'(0);
    localparam logic [PCHTYPE_BW-1:0] T_ZT  = PCHTYPE_BW'(1);
    localparam logic [PCHTYPE_BW-1:0] T_ZB  = PCHTYPE_BW'(2);
    localparam logic [PCHTYPE_BW-1:0] T_MT  = PCHTYPE_BW'(3);
    localparam logic [PCHTYPE_BW-1:0] T_MB  = PCHTYPE_BW'(4);
    localparam logic [PCHTYPE_BW-1:0] T_M   = PCHTYPE_BW'(5);
    localparam logic [PCHTYPE_BW-1:0] T_X   = PCHTYPE_BW'(6);
    localparam logic [PCHTYPE_BW-1:0] T_AW  = PCHTYPE_BW'(7);
    localparam logic [PCHTYPE_BW-1:0] T_AE  = PCHTYPE_BW'(8);
    localparam logic [PCHTYPE_BW-1:0] T_AC  = PCHTYPE_BW'(9);
    localparam logic [PCHTYPE_BW-1:0] T_AWE = PCHTYPE_BW'(10);
    // Boundary-location codes: I=0 N=1 S=2 E=3 W=4 WE=5.
    localparam logic [BDLOC_BW-1:0] B_I  = BDLOC_BW'(0);
    localparam logic [BDLOC_BW-1:0] B_N  = BDLOC_BW'(1);
    localparam logic [BDLOC_BW-1:0] B_S  = BDLOC_BW'(2);
    localparam logic [BDLOC_BW-1:0] B_E  = BDLOC_BW'(3);
    localparam logic [BDLOC_BW-1:0] B_W  = BDLOC_BW'(4);
    localparam logic [BDLOC_BW-1:0] B_WE = BDLOC_BW'(5);

    localparam logic [PCHADDR_BW-1:0] LAST = PCHADDR_BW'(NUM_PCH - 1);

    typedef enum logic {INIT, READY} state_t;

    function automatic logic [PCHSTAT_BW-1:0] def_entry(input int i);
        int r;
        int c;
        logic [PCHTYPE_BW-1:0] t;
        logic [BDLOC_BW-1:0] z;
        logic [BDLOC_BW-1:0] x;
        r = i / NUM_PCHCOL;
        c = i % NUM_PCHCOL;
        t = T_I;
        z = B_I;
        x = B_I;
        // First match wins; anything unmatched (incl. rows >= 3) stays I{I,I}.
        if (r == 0 && c == 0) begin
            t = T_ZT;
            x = B_E;
        end else if (r == 1 && c == 0) begin
            t = T_ZB;
            z = B_E;
        end else if (r == 0 && c == 1) begin
            t = T_MT;
            z = B_W;
        end else if (r == 1 && c == 1) begin
            t = T_MB;
            z = B_WE;
        end else if (r == 0 && c != NUM_PCHCOL - 1) begin
            t = T_M;
            z = B_S;
        end else if (r == 2 && c > 1 && c != NUM_PCHCOL - 1) begin
            t = T_M;
            z = B_N;
        end else if (r == 1 && c == NUM_PCHCOL - 1) begin
            t = T_X;
            z = B_W;
        end else if (r == 1 && c == 2 && c == NUM_PCHCOL - 2) begin
            t = T_AWE;
        end else if (r == 1 && c == 2) begin
            t = T_AW;
        end else if (r == 1 && c == NUM_PCHCOL - 2) begin
            t = T_AE;
        end else if (r == 1) begin
            t = T_AC;
        end
        return {t, z, x};
    endfunction

    logic [PCHSTAT_BW-1:0] def_tbl [NUM_PCH];
    for (genvar g = 0; g < NUM_PCH; g++) begin : g_def
        assign def_tbl[g] = def_entry(g);
    end

    state_t                          state_q, state_d;
    logic [PCHADDR_BW-1:0]           cnt_q, cnt_d;
    logic                            init_done_q, init_done_d;
    logic [PCHSTAT_BW-1:0]           mem_q [NUM_PCH];
    logic [NUM_RDPORT-1:0]           rd_valid_q, rd_valid_d;
    logic [NUM_RDPORT-1:0]           rd_err_q, rd_err_d;
    logic [NUM_RDPORT*PCHSTAT_BW-1:0] rd_data_q, rd_data_d;
    logic                            wr_err_q, wr_err_d;
    logic                            wr_ok;
    logic [PCHADDR_BW-1:0]           idx;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == INIT) begin
            cnt_d = (reinit_req || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (!reinit_req && cnt_q == LAST) begin
                state_d     = READY;
                init_done_d = 1'b1;
            end
        end else if (reinit_req) begin
            state_d     = INIT;
            cnt_d       = '0;
            init_done_d = 1'b0;
        end
    end

    // Reinit beats a concurrent write; the write is reported as rejected.
    assign wr_ok    = wr_en && init_done_q && !reinit_req && wr_idx <= LAST;
    assign wr_err_d = wr_en && !wr_ok;

    always_comb begin
        rd_valid_d = '0;
        rd_err_d   = '0;
        rd_data_d  = '0;
        idx        = '0;
        for (int p = 0; p < NUM_RDPORT; p++) begin
            idx           = rd_idx[p*PCHADDR_BW +: PCHADDR_BW];
            rd_valid_d[p] = rd_en[p] && init_done_q;
            rd_err_d[p]   = rd_valid_d[p] && idx > LAST;
            rd_data_d[p*PCHSTAT_BW +: PCHSTAT_BW] = (rd_valid_d[p] && !rd_err_d[p]) ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_valid_q  <= '0;
            rd_err_q    <= '0;
            rd_data_q   <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            rd_data_q   <= rd_data_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Table storage carries no reset; it is only meaningful once the walk completes.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            mem_q[cnt_q] <= def_tbl[cnt_q];
        else if (wr_ok)
            mem_q[wr_idx] <= wr_data;
    end

    assign init_done = init_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign rd_data   = rd_data_q;
    assign wr_err    = wr_err_q;
endmodule

// File: tb/tb_piu_pchinfo_table.sv
// tb_piu_pchinfo_table: scoreboard bench for the default 6x3 table and a 4x4 variant.
module tb_piu_pchinfo_table;
    localparam logic [3:0] T_I = 4'd0, T_ZT = 4'd1, T_ZB = 4'd2, T_MT = 4'd3, T_MB = 4'd4, T_M = 4'd5;
    localparam logic [3:0] T_X = 4'd6, T_AW = 4'd7, T_AE = 4'd8, T_AC = 4'd9, T_AWE = 4'd10;
    localparam logic [2:0] B_I = 3'd0, B_N = 3'd1, B_S = 3'd2, B_E = 3'd3, B_W = 3'd4, B_WE = 3'd5;

    typedef struct {
        int         idx;
        logic [9:0] d;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done, reinit_req, wr_en, wr_err;
    logic [1:0]  rd_en, rd_valid, rd_err;
    logic [9:0]  rd_idx;
    logic [19:0] rd_data;
    logic [4:0]  wr_idx;
    logic [9:0]  wr_data;

    logic        init_done4, reinit4, wr_en4, wr_err4;
    logic [1:0]  rd_en4, rd_valid4, rd_err4;
    logic [7:0]  rd_idx4;
    logic [19:0] rd_data4;
    logic [3:0]  wr_idx4;
    logic [9:0]  wr_data4;

    int checks = 0;
    int errors = 0;
    exp_t q0[$], q1[$], q2[$];
    logic [9:0] exp6 [18];
    logic [9:0] exp4 [16];

    always #5 clk = ~clk;

    piu_pchinfo_table u_dut (
        .clk(clk), .rst(rst), .init_done(init_done), .reinit_req(reinit_req),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_err(wr_err)
    );

    piu_pchinfo_table #(.NUM_PCHROW(4), .NUM_PCHCOL(4)) u_dut4 (
        .clk(clk), .rst(rst), .init_done(init_done4), .reinit_req(reinit4),
        .rd_en(rd_en4), .rd_idx(rd_idx4), .rd_valid(rd_valid4), .rd_data(rd_data4), .rd_err(rd_err4),
        .wr_en(wr_en4), .wr_idx(wr_idx4), .wr_data(wr_data4), .wr_err(wr_err4)
    );

    function automatic logic [9:0] ent(input logic [3:0] t, input logic [2:0] z, input logic [2:0] x);
        return {t, z, x};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rd(input string pfx, input exp_t e, input logic [9:0] d, input logic er);
        check($sformatf("%s_data_idx%0d", pfx, e.idx), 32'(d), 32'(e.d));
        check($sformatf("%s_err_idx%0d", pfx, e.idx), 32'(er), 32'(e.e));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid[0]) begin
            if (q0.size() == 0) check("p0_unexpected_valid", 32'(rd_valid[0]), 32'd0);
            else begin
                e = q0.pop_front();
                check_rd("p0", e, rd_data[9:0], rd_err[0]);
            end
        end
        if (rd_valid[1]) begin
            if (q1.size() == 0) check("p1_unexpected_valid", 32'(rd_valid[1]), 32'd0);
            else begin
                e = q1.pop_front();
                check_rd("p1", e, rd_data[19:10], rd_err[1]);
            end
        end
        if (rd_valid4[0]) begin
            if (q2.size() == 0) check("d4_unexpected_valid", 32'(rd_valid4[0]), 32'd0);
            else begin
                e = q2.pop_front();
                check_rd("d4", e, rd_data4[9:0], rd_err4[0]);
            end
        end
    end

    task automatic rd(input int p, input int idx, input logic [9:0] d, input logic e);
        exp_t x;
        x.idx = idx;
        x.d   = d;
        x.e   = e;
        if (p == 2) begin
            rd_en4[0]    = 1'b1;
            rd_idx4[3:0] = 4'(idx);
            q2.push_back(x);
        end else begin
            rd_en[p]          = 1'b1;
            rd_idx[p*5 +: 5]  = 5'(idx);
            if (p == 0) q0.push_back(x);
            else q1.push_back(x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rd_en      = '0;
        rd_en4     = '0;
        wr_en      = 1'b0;
        reinit_req = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done) break;
        end
        rd_en = '0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; reinit_req = 1'b0; rd_en = '0; rd_idx = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        reinit4 = 1'b0; rd_en4 = '0; rd_idx4 = '0; wr_en4 = 1'b0; wr_idx4 = '0; wr_data4 = '0;
        exp6 = '{ent(T_ZT,B_I,B_E), ent(T_MT,B_W,B_I), ent(T_M,B_S,B_I), ent(T_M,B_S,B_I), ent(T_M,B_S,B_I),
                 ent(T_I,B_I,B_I), ent(T_ZB,B_E,B_I), ent(T_MB,B_WE,B_I), ent(T_AW,B_I,B_I), ent(T_AC,B_I,B_I),
                 ent(T_AE,B_I,B_I), ent(T_X,B_W,B_I), ent(T_I,B_I,B_I), ent(T_I,B_I,B_I), ent(T_M,B_N,B_I),
                 ent(T_M,B_N,B_I), ent(T_M,B_N,B_I), ent(T_I,B_I,B_I)};
        exp4 = '{ent(T_ZT,B_I,B_E), ent(T_MT,B_W,B_I), ent(T_M,B_S,B_I), ent(T_I,B_I,B_I),
                 ent(T_ZB,B_E,B_I), ent(T_MB,B_WE,B_I), ent(T_AWE,B_I,B_I), ent(T_X,B_W,B_I),
                 ent(T_I,B_I,B_I), ent(T_I,B_I,B_I), ent(T_M,B_N,B_I), ent(T_I,B_I,B_I),
                 ent(T_I,B_I,B_I), ent(T_I,B_I,B_I), ent(T_I,B_I,B_I), ent(T_I,B_I,B_I)};
        repeat (3) @(negedge clk);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);

        // rd_en held during the walk must not produce any response
        rd_en  = 2'b11;
        rd_idx = {5'd1, 5'd0};
        rst    = 1'b0;
        wait_done(n);
        check("init_edges", 32'(n), 32'd18);
        check("dut4_init_done", 32'(init_done4), 32'd1);

        for (int i = 0; i < 18; i++) begin
            rd(0, i, exp6[i], 1'b0);
            rd(1, 17 - i, exp6[17-i], 1'b0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            rd(2, i, exp4[i], 1'b0);
            tick();
        end

        // same-cycle read/write to idx9 plus an out-of-range read
        rd(0, 9, ent(T_AC,B_I,B_I), 1'b0);
        rd(1, 20, 10'd0, 1'b1);
        wr_en = 1'b1; wr_idx = 5'd9; wr_data = ent(T_X,B_W,B_I);
        tick();
        check("wr9_err", 32'(wr_err), 32'd0);
        rd(0, 9, ent(T_X,B_W,B_I), 1'b0);
        rd(1, 9, ent(T_X,B_W,B_I), 1'b0);
        tick();
        wr_en = 1'b1; wr_idx = 5'd25; wr_data = ent(T_AC,B_N,B_N);
        tick();
        check("wr_oor_err", 32'(wr_err), 32'd1);
        rd(0, 31, 10'd0, 1'b1);
        tick();
        check("wr_err_pulse_end", 32'(wr_err), 32'd0);

        // runtime write, then reinit colliding with a write
        wr_en = 1'b1; wr_idx = 5'd3; wr_data = ent(T_AE,B_N,B_N);
        tick();
        rd(0, 3, ent(T_AE,B_N,B_N), 1'b0);
        tick();
        reinit_req = 1'b1;
        wr_en = 1'b1; wr_idx = 5'd4; wr_data = ent(T_X,B_W,B_I);
        rd(1, 3, ent(T_AE,B_N,B_N), 1'b0);
        tick();
        check("reinit_wr_err", 32'(wr_err), 32'd1);
        check("reinit_done_low", 32'(init_done), 32'd0);
        wr_en = 1'b1; wr_idx = 5'd4; wr_data = ent(T_X,B_W,B_I);
        tick();
        check("init_wr_err", 32'(wr_err), 32'd1);
        wait_done(n);
        check("reinit_edges", 32'(n + 1), 32'd18);
        rd(0, 3, ent(T_M,B_S,B_I), 1'b0);
        rd(1, 4, ent(T_M,B_S,B_I), 1'b0);
        tick();

        // async reset during a live read response
        rd_en[0] = 1'b1; rd_idx[4:0] = 5'd2; wr_en = 1'b1; wr_idx = 5'd30;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(rd_valid[0]), 32'd1);
        check("pre_rst_data", 32'(rd_data[9:0]), 32'(ent(T_M,B_S,B_I)));
        check("pre_rst_wr_err", 32'(wr_err), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rd_valid), 32'd0);
        check("async_rst_data", 32'(rd_data), 32'd0);
        check("async_rst_wr_err", 32'(wr_err), 32'd0);
        check("async_rst_done", 32'(init_done), 32'd0);
        rd_en = '0; wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_done(n);
        check("rst_ready_edges", 32'(n), 32'd18);

        // async reset at cnt=7 of a reinit walk
        reinit_req = 1'b1;
        tick();
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midwalk_rst_done", 32'(init_done), 32'd0);
        check("midwalk_rst_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(n);
        check("midwalk_edges", 32'(n), 32'd18);
        for (int i = 0; i < 18; i++) begin
            rd(1, i, exp6[i], 1'b0);
            tick();
        end
        tick();
        check("sb_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
